// File: rtl/noc_link_elastic_buffer_pkg.sv
// rtl/noc_link_elastic_buffer_pkg.sv - shared defaults and types for the NoC link elastic buffer
//
// Purpose: default link depth / stop slack and a count type wide enough for
// the largest supported channel FIFO (64 entries).
// Ports: none (package).
package noc_link_elastic_buffer_pkg;

    localparam int kDefaultLinkDepth = 4;
    localparam int kDefaultStopSlack = 1;
    localparam int kMaxLinkDepth     = 64;

    // Holds any occupancy value 0..kMaxLinkDepth.
    typedef logic [$clog2(kMaxLinkDepth + 1)-1:0] link_cnt_t;

endpackage

// File: rtl/noc_stopvoid_fifo.sv
// rtl/noc_stopvoid_fifo.sv - single-channel stop/void FIFO with early stop and sticky overflow
//
// Purpose: one elastic-buffer channel. Flits arrive with a void flag, leave
// with a void flag, and the upstream is told to stop early enough that a
// sender with up to StopSlack cycles of reaction latency never overflows.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_data     incoming flit
//   push_void     1 = no incoming flit this cycle
//   stop_out      registered backpressure to upstream (advisory)
//   pop_data      head flit, read straight from the storage array
//   pop_void      1 = FIFO empty
//   stop_in       downstream backpressure, holds the head in place
//   overflow_err  sticky, set when a flit had to be dropped
//   occupancy     current entry count
module noc_stopvoid_fifo
    import noc_link_elastic_buffer_pkg::*;
#(
    parameter int Width     = 32,
    parameter int Depth     = kDefaultLinkDepth,
    parameter int StopSlack = kDefaultStopSlack
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Width-1:0]           push_data,
    input  logic                       push_void,
    output logic                       stop_out,
    output logic [Width-1:0]           pop_data,
    output logic                       pop_void,
    input  logic                       stop_in,
    output logic                       overflow_err,
    output logic [$clog2(Depth+1)-1:0] occupancy
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = $clog2(Depth);

    localparam logic [CntW-1:0] DepthCnt  = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(Depth - 1);
    localparam link_cnt_t       StopLevel = link_cnt_t'(Depth - StopSlack);

    if (Depth < 2 || Depth > kMaxLinkDepth || StopSlack < 0 || StopSlack >= Depth) begin : g_bad_params
        $error("noc_stopvoid_fifo: need 2 <= Depth <= 64 and 0 <= StopSlack < Depth");
    end

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             stop_q, stop_d;
    logic             ovf_q, ovf_d;

    logic push;
    logic pop;
    logic accept;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        push   = ~push_void;
        pop    = (count_q != '0) && ~stop_in;
        // A full FIFO still takes a flit when the head leaves on the same edge.
        accept = push && ((count_q != DepthCnt) || pop);

        if (accept) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        end

        if (push && !accept) begin
            ovf_d = 1'b1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Stop is raised from the post-edge count so it is visible in the
        // same cycle the FIFO reaches the slack threshold.
        stop_d = (link_cnt_t'(count_d) >= StopLevel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stop_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stop_q   <= stop_d;
            ovf_q    <= ovf_d;
        end
    end

    assign pop_data     = mem_q[rd_ptr_q];
    assign pop_void     = (count_q == '0);
    assign stop_out     = stop_q;
    assign overflow_err = ovf_q;
    assign occupancy    = count_q;

endmodule

// File: rtl/noc_link_elastic_buffer.sv
// rtl/noc_link_elastic_buffer.sv - multi-channel stop/void elastic buffer for NoC links
//
// Purpose: decouples link retiming from router timing by placing a FIFO on
// each enabled channel. Channel i (N/S/W/E/P for i = 0..4) is present when
// PortMask[i] = 1; disabled channels are constant tie-offs with no state.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   data_in        NumPorts flits, channel i at [i*Width +: Width]
//   data_void_in   1 = no flit on channel i
//   stop_out       registered backpressure to upstream
//   data_out       head flit of each channel
//   data_void_out  1 = channel i empty
//   stop_in        downstream backpressure per channel
//   overflow_err   sticky per-channel drop indicator
//   occupancy      per-channel entry count, $clog2(Depth+1) bits each
module noc_link_elastic_buffer
    import noc_link_elastic_buffer_pkg::*;
#(
    parameter int                  Width     = 32,
    parameter int                  NumPorts  = 5,
    parameter logic [NumPorts-1:0] PortMask  = '1,
    parameter int                  Depth     = kDefaultLinkDepth,
    parameter int                  StopSlack = kDefaultStopSlack
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NumPorts*Width-1:0]           data_in,
    input  logic [NumPorts-1:0]                 data_void_in,
    output logic [NumPorts-1:0]                 stop_out,
    output logic [NumPorts*Width-1:0]           data_out,
    output logic [NumPorts-1:0]                 data_void_out,
    input  logic [NumPorts-1:0]                 stop_in,
    output logic [NumPorts-1:0]                 overflow_err,
    output logic [NumPorts*$clog2(Depth+1)-1:0] occupancy
);

    localparam int CntW = $clog2(Depth + 1);

    for (genvar i = 0; i < NumPorts; i++) begin : g_ch
        if (PortMask[i]) begin : g_on
            noc_stopvoid_fifo #(
                .Width     (Width),
                .Depth     (Depth),
                .StopSlack (StopSlack)
            ) u_fifo (
                .clk          (clk),
                .rst          (rst),
                .push_data    (data_in[i*Width +: Width]),
                .push_void    (data_void_in[i]),
                .stop_out     (stop_out[i]),
                .pop_data     (data_out[i*Width +: Width]),
                .pop_void     (data_void_out[i]),
                .stop_in      (stop_in[i]),
                .overflow_err (overflow_err[i]),
                .occupancy    (occupancy[i*CntW +: CntW])
            );
        end else begin : g_off
            logic unused_inputs;
            assign unused_inputs                 = ^{data_in[i*Width +: Width], data_void_in[i], stop_in[i]};
            assign stop_out[i]                   = 1'b0;
            assign data_out[i*Width +: Width]    = '0;
            assign data_void_out[i]              = 1'b1;
            assign overflow_err[i]               = 1'b0;
            assign occupancy[i*CntW +: CntW]     = '0;
        end
    end

endmodule

// File: tb/tb_noc_link_elastic_buffer.sv
// tb/tb_noc_link_elastic_buffer.sv - directed self-checking bench for noc_link_elastic_buffer
module tb_noc_link_elastic_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: Depth 4, StopSlack 1, channel 3 masked off.
    logic [159:0] a_data_in, a_data_out;
    logic [4:0]   a_void_in, a_stop_out, a_void_out, a_stop_in, a_ovf;
    logic [14:0]  a_occ;

    // Instance B: Depth 3 (non power of two), all channels present.
    logic [159:0] b_data_in, b_data_out;
    logic [4:0]   b_void_in, b_stop_out, b_void_out, b_stop_in, b_ovf;
    logic [9:0]   b_occ;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_data [5][100];
    int          sent [5];
    int          rcvd [5];

    noc_link_elastic_buffer #(
        .Width(32), .NumPorts(5), .PortMask(5'b10111), .Depth(4), .StopSlack(1)
    ) dut_a (
        .clk(clk), .rst(rst), .data_in(a_data_in), .data_void_in(a_void_in),
        .stop_out(a_stop_out), .data_out(a_data_out), .data_void_out(a_void_out),
        .stop_in(a_stop_in), .overflow_err(a_ovf), .occupancy(a_occ)
    );

    noc_link_elastic_buffer #(
        .Width(32), .NumPorts(5), .PortMask(5'b11111), .Depth(3), .StopSlack(1)
    ) dut_b (
        .clk(clk), .rst(rst), .data_in(b_data_in), .data_void_in(b_void_in),
        .stop_out(b_stop_out), .data_out(b_data_out), .data_void_out(b_void_out),
        .stop_in(b_stop_in), .overflow_err(b_ovf), .occupancy(b_occ)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_data_in = '0; a_void_in = '1; a_stop_in = '0;
        b_data_in = '0; b_void_in = '1; b_stop_in = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (a_void_out !== 5'h1f || b_void_out !== 5'h1f) begin
            n_errors++;
            $display("FAIL reset_void: a=%b b=%b expected 11111", a_void_out, b_void_out);
        end
        n_checks++;
        if (a_stop_out !== 5'h0 || b_stop_out !== 5'h0) begin
            n_errors++;
            $display("FAIL reset_stop: a=%b b=%b expected 00000", a_stop_out, b_stop_out);
        end
        n_checks++;
        if (a_data_out !== '0 || b_data_out !== '0) begin
            n_errors++;
            $display("FAIL reset_data: a=%h b=%h expected 0", a_data_out, b_data_out);
        end
        n_checks++;
        if (a_ovf !== 5'h0 || b_ovf !== 5'h0 || a_occ !== '0 || b_occ !== '0) begin
            n_errors++;
            $display("FAIL reset_ovf_occ: ovf a=%b b=%b occ a=%h b=%h expected 0", a_ovf, b_ovf, a_occ, b_occ);
        end
    endtask

    task automatic test_single_flit();
        a_data_in[64 +: 32] = 32'hA5A5_0001;
        a_void_in[2] = 1'b0;
        step();
        a_void_in[2] = 1'b1;
        n_checks++;
        if (a_void_out[2] !== 1'b0 || a_data_out[64 +: 32] !== 32'hA5A5_0001 || a_occ[6 +: 3] !== 3'd1) begin
            n_errors++;
            $display("FAIL single_visible: void=%b data=%h occ=%0d expected 0 a5a50001 1",
                     a_void_out[2], a_data_out[64 +: 32], a_occ[6 +: 3]);
        end
        step();
        n_checks++;
        if (a_void_out[2] !== 1'b1 || a_occ[6 +: 3] !== 3'd0) begin
            n_errors++;
            $display("FAIL single_gone: void=%b occ=%0d expected 1 0", a_void_out[2], a_occ[6 +: 3]);
        end
    endtask

    task automatic fill_ch0();
        a_stop_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_data_in[31:0] = 32'(k + 1);
            a_void_in[0]    = 1'b0;
            step();
            n_checks++;
            if (a_occ[2:0] !== 3'(k + 1) || a_stop_out[0] !== (k >= 2)) begin
                n_errors++;
                $display("FAIL fill_push%0d: occ=%0d stop=%b expected %0d %b",
                         k + 1, a_occ[2:0], a_stop_out[0], k + 1, (k >= 2));
            end
        end
        a_void_in[0] = 1'b1;
    endtask

    task automatic test_fill_stop();
        apply_reset();
        fill_ch0();
        a_data_in[31:0] = 32'd99;
        a_void_in[0]    = 1'b0;
        step();
        a_void_in[0]    = 1'b1;
        n_checks++;
        if (a_ovf[0] !== 1'b1 || a_occ[2:0] !== 3'd4 || a_data_out[31:0] !== 32'd1) begin
            n_errors++;
            $display("FAIL overflow5: ovf=%b occ=%0d head=%0d expected 1 4 1",
                     a_ovf[0], a_occ[2:0], a_data_out[31:0]);
        end
    endtask

    task automatic test_full_stream();
        apply_reset();
        fill_ch0();
        a_stop_in[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a_data_in[31:0] = 32'(k + 5);
            a_void_in[0]    = 1'b0;
            n_checks++;
            if (a_data_out[31:0] !== 32'(k + 1) || a_void_out[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL stream_head%0d: data=%0d void=%b expected %0d 0",
                         k, a_data_out[31:0], a_void_out[0], k + 1);
            end
            step();
            n_checks++;
            if (a_occ[2:0] !== 3'd4 || a_ovf[0] !== 1'b0 || a_stop_out[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_full%0d: occ=%0d ovf=%b stop=%b expected 4 0 1",
                         k, a_occ[2:0], a_ovf[0], a_stop_out[0]);
            end
        end
        a_void_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (a_data_out[31:0] !== 32'(k + 9)) begin
                n_errors++;
                $display("FAIL drain_head%0d: data=%0d expected %0d", k, a_data_out[31:0], k + 9);
            end
            step();
            n_checks++;
            if (a_occ[2:0] !== 3'(3 - k) || a_stop_out[0] !== (k == 0)) begin
                n_errors++;
                $display("FAIL drain_occ%0d: occ=%0d stop=%b expected %0d %b",
                         k, a_occ[2:0], a_stop_out[0], 3 - k, (k == 0));
            end
        end
        n_checks++;
        if (a_void_out[0] !== 1'b1 || a_ovf[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_empty: void=%b ovf=%b expected 1 0", a_void_out[0], a_ovf[0]);
        end
    endtask

    task automatic test_wrap_random();
        bit all_done;
        int cyc;
        int cnt;
        logic [31:0] d;
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            sent[c] = 0;
            rcvd[c] = 0;
        end
        all_done = 1'b0;
        cyc = 0;
        while (!all_done && cyc < 3000) begin
            for (int c = 0; c < 5; c++) begin
                cnt = sent[c] - rcvd[c];
                n_checks++;
                if (b_void_out[c] !== (cnt == 0) || b_occ[c*2 +: 2] !== 2'(cnt) || b_stop_out[c] !== (cnt >= 2)) begin
                    n_errors++;
                    $display("FAIL wrap_state ch%0d cyc%0d: void=%b occ=%0d stop=%b expected %b %0d %b",
                             c, cyc, b_void_out[c], b_occ[c*2 +: 2], b_stop_out[c], (cnt == 0), cnt, (cnt >= 2));
                end
                if (cnt > 0) begin
                    n_checks++;
                    if (b_data_out[c*32 +: 32] !== exp_data[c][rcvd[c]]) begin
                        n_errors++;
                        $display("FAIL wrap_data ch%0d idx%0d: data=%h expected %h",
                                 c, rcvd[c], b_data_out[c*32 +: 32], exp_data[c][rcvd[c]]);
                    end
                end
                b_stop_in[c] = 1'($urandom_range(0, 1));
                b_void_in[c] = 1'b1;
                if (sent[c] < 100 && !b_stop_out[c] && $urandom_range(0, 3) != 0) begin
                    d = $urandom();
                    b_data_in[c*32 +: 32] = d;
                    b_void_in[c] = 1'b0;
                    exp_data[c][sent[c]] = d;
                end
                if (cnt > 0 && !b_stop_in[c]) rcvd[c]++;
                if (!b_void_in[c]) sent[c]++;
            end
            step();
            cyc++;
            all_done = 1'b1;
            for (int c = 0; c < 5; c++) begin
                if (rcvd[c] < 100 || sent[c] != rcvd[c]) all_done = 1'b0;
            end
        end
        b_void_in = '1;
        b_stop_in = '0;
        n_checks++;
        if (!all_done) begin
            n_errors++;
            $display("FAIL wrap_timeout: stream not drained after %0d cycles", cyc);
        end
        n_checks++;
        if (b_ovf !== 5'h0 || b_void_out !== 5'h1f) begin
            n_errors++;
            $display("FAIL wrap_final: ovf=%b void=%b expected 00000 11111", b_ovf, b_void_out);
        end
    endtask

    task automatic test_masked();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            a_data_in[96 +: 32] = $urandom();
            a_void_in[3] = 1'b0;
            a_stop_in[3] = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if (a_stop_out[3] !== 1'b0 || a_void_out[3] !== 1'b1 || a_data_out[96 +: 32] !== 32'h0 ||
                a_occ[9 +: 3] !== 3'd0 || a_ovf[3] !== 1'b0) begin
                n_errors++;
                $display("FAIL masked_ch3 cyc%0d: stop=%b void=%b data=%h occ=%0d ovf=%b expected 0 1 0 0 0",
                         k, a_stop_out[3], a_void_out[3], a_data_out[96 +: 32], a_occ[9 +: 3], a_ovf[3]);
            end
        end
        a_void_in[3] = 1'b1;
        a_stop_in[3] = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        a_stop_in[0] = 1'b1;
        a_stop_in[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a_data_in[31:0]  = 32'(k + 20);
            a_void_in[0]     = 1'b0;
            a_data_in[63:32] = 32'(k + 40);
            a_void_in[1]     = (k >= 3);
            step();
        end
        a_void_in = '1;
        n_checks++;
        if (a_occ[5:3] !== 3'd3 || a_ovf[0] !== 1'b1 || a_stop_out[1:0] !== 2'b11) begin
            n_errors++;
            $display("FAIL areset_pre: occ1=%0d ovf0=%b stop=%b expected 3 1 11",
                     a_occ[5:3], a_ovf[0], a_stop_out[1:0]);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_void_out !== 5'h1f || a_stop_out !== 5'h0 || a_ovf !== 5'h0 || a_occ !== '0) begin
            n_errors++;
            $display("FAIL areset_now: void=%b stop=%b ovf=%b occ=%h expected 11111 00000 00000 0",
                     a_void_out, a_stop_out, a_ovf, a_occ);
        end
        #1;
        rst = 1'b0;
        a_stop_in = '0;
        a_data_in[63:32] = 32'hDEAD_BEEF;
        a_void_in[1] = 1'b0;
        step();
        a_void_in[1] = 1'b1;
        n_checks++;
        if (a_void_out[1] !== 1'b0 || a_data_out[63:32] !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL areset_first: void=%b data=%h expected 0 deadbeef", a_void_out[1], a_data_out[63:32]);
        end
        step();
        n_checks++;
        if (a_void_out[1] !== 1'b1 || a_occ[5:3] !== 3'd0) begin
            n_errors++;
            $display("FAIL areset_drain: void=%b occ=%0d expected 1 0", a_void_out[1], a_occ[5:3]);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_flit();
        test_fill_stop();
        test_full_stream();
        test_wrap_random();
        test_masked();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
